// File: rtl/wr_burst_gen.sv
// Write-source stage: slices a valid/ready user beat stream into fixed-size bursts
// on a circular address window and emits beats plus one command per burst.
// A one-beat hold register delays each beat so the burst-final marker can always
// be placed on a real beat, and the command is issued on the same cycle as that beat.
module wr_burst_gen #(
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned BURST_LEN      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_end_addr,
    input  logic                      wr_start,
    input  logic                      wr_stop,
    input  logic [AXI_DATA_WIDTH-1:0] user_wr_data,
    input  logic                      user_wr_valid,
    output logic                      user_wr_ready,
    output logic                      wr_req_en,
    output logic [7:0]                wr_burst_length,
    output logic [AXI_ADDR_WIDTH-1:0] wr_data_addr,
    output logic [AXI_DATA_WIDTH-1:0] wr_data_din,
    output logic                      wr_data_valid,
    output logic                      wr_data_last,
    output logic                      wr_busy,
    output logic [31:0]               wr_burst_cnt
);

    // Byte distance between consecutive burst slots in the window.
    localparam int unsigned StrideBytes = BURST_LEN * AXI_DATA_WIDTH / 8;
    localparam int unsigned CntW        = 9;
    localparam logic [CntW-1:0]         BurstLenC = CntW'(BURST_LEN);
    localparam logic [AXI_ADDR_WIDTH:0] StrideC   = (AXI_ADDR_WIDTH + 1)'(StrideBytes);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    state_e                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] base_q;
    logic [AXI_ADDR_WIDTH-1:0] end_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_ptr_q;
    // Beats accepted into the open burst, including the one sitting in the hold register.
    logic [CntW-1:0]           beat_cnt_q;
    logic                      hold_vld_q;
    logic [AXI_DATA_WIDTH-1:0] hold_data_q;

    logic                      req_q;
    logic [7:0]                len_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] din_q;
    logic                      dvalid_q;
    logic                      dlast_q;
    logic                      busy_q;
    logic [31:0]               burst_cnt_q;

    logic                      ready;
    logic                      accept;
    logic                      hold_final;
    logic                      flush_drain;
    logic                      emit;
    logic                      close;
    logic [AXI_ADDR_WIDTH:0]   addr_sum;
    logic [AXI_ADDR_WIDTH-1:0] addr_next;
    logic [7:0]                close_len;

    // Handshake, beat-release and burst-close decisions for the coming edge.
    always_comb begin
        ready       = (state_q == StRun) && !wr_stop;
        accept      = ready && user_wr_valid;
        // The held beat is always the newest one, so its index is beat_cnt_q - 1.
        hold_final  = hold_vld_q && (beat_cnt_q == BurstLenC);
        flush_drain = (state_q == StFlush) && hold_vld_q;
        emit        = hold_vld_q && (accept || hold_final || flush_drain);
        close       = emit && (hold_final || flush_drain);
        // Full bursts have beat_cnt_q == BURST_LEN, so one formula covers both cases.
        close_len   = 8'(beat_cnt_q - 9'd1);
        addr_sum    = {1'b0, addr_ptr_q} + StrideC;
        // Partial bursts also advance a full stride so slots stay aligned.
        if (addr_sum >= {1'b0, end_q}) begin
            addr_next = base_q;
        end else begin
            addr_next = addr_sum[AXI_ADDR_WIDTH-1:0];
        end
    end

    // Session FSM, hold register, burst bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            end_q       <= '0;
            addr_ptr_q  <= '0;
            beat_cnt_q  <= '0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            req_q       <= 1'b0;
            len_q       <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            dvalid_q    <= 1'b0;
            dlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            // Strobes are single-cycle by construction.
            dvalid_q <= emit;
            dlast_q  <= close;
            req_q    <= close;

            if (emit) begin
                din_q <= hold_data_q;
            end

            if (close) begin
                len_q       <= close_len;
                addr_q      <= addr_ptr_q;
                addr_ptr_q  <= addr_next;
                burst_cnt_q <= burst_cnt_q + 32'd1;
            end

            // A newly accepted beat refills the hold register on the same edge it empties.
            if (accept) begin
                hold_data_q <= user_wr_data;
                hold_vld_q  <= 1'b1;
            end else if (emit) begin
                hold_vld_q  <= 1'b0;
            end

            if (close) begin
                beat_cnt_q <= accept ? 9'd1 : 9'd0;
            end else if (accept) begin
                beat_cnt_q <= beat_cnt_q + 9'd1;
            end

            case (state_q)
                StIdle: begin
                    // Hold register is always empty here, so no close can collide.
                    if (wr_start) begin
                        state_q     <= StRun;
                        base_q      <= cfg_base_addr;
                        end_q       <= cfg_end_addr;
                        addr_ptr_q  <= cfg_base_addr;
                        beat_cnt_q  <= '0;
                        burst_cnt_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                StRun: begin
                    if (wr_stop) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign user_wr_ready   = ready;
    assign wr_req_en       = req_q;
    assign wr_burst_length = len_q;
    assign wr_data_addr    = addr_q;
    assign wr_data_din     = din_q;
    assign wr_data_valid   = dvalid_q;
    assign wr_data_last    = dlast_q;
    assign wr_busy         = busy_q;
    assign wr_burst_cnt    = burst_cnt_q;

endmodule

// File: tb/tb_wr_burst_gen.sv
// Bench for wr_burst_gen: random beats checked against a queue-based model of the
// burst slicing (beat order, burst boundaries, window addresses, close latency).
module tb_wr_burst_gen;

    localparam int unsigned DW     = 128;
    localparam int unsigned AW     = 32;
    localparam int unsigned BL     = 16;
    localparam int unsigned STRIDE = BL * DW / 8;

    typedef logic [DW-1:0] val_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [AW-1:0] cfg_end_addr = '0;
    logic          wr_start = 1'b0;
    logic          wr_stop = 1'b0;
    logic [DW-1:0] user_wr_data = '0;
    logic          user_wr_valid = 1'b0;
    logic          user_wr_ready;
    logic          wr_req_en;
    logic [7:0]    wr_burst_length;
    logic [AW-1:0] wr_data_addr;
    logic [DW-1:0] wr_data_din;
    logic          wr_data_valid;
    logic          wr_data_last;
    logic          wr_busy;
    logic [31:0]   wr_burst_cnt;

    wr_burst_gen #(
        .AXI_DATA_WIDTH(DW),
        .AXI_ADDR_WIDTH(AW),
        .BURST_LEN     (BL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_end_addr   (cfg_end_addr),
        .wr_start       (wr_start),
        .wr_stop        (wr_stop),
        .user_wr_data   (user_wr_data),
        .user_wr_valid  (user_wr_valid),
        .user_wr_ready  (user_wr_ready),
        .wr_req_en      (wr_req_en),
        .wr_burst_length(wr_burst_length),
        .wr_data_addr   (wr_data_addr),
        .wr_data_din    (wr_data_din),
        .wr_data_valid  (wr_data_valid),
        .wr_data_last   (wr_data_last),
        .wr_busy        (wr_busy),
        .wr_burst_cnt   (wr_burst_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: session flags, current slot, accepted-but-unchecked beats, closed commands.
    logic          m_run = 1'b0;
    logic          m_flush = 1'b0;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_end = '0;
    logic [AW-1:0] m_addr = '0;
    int            m_cnt = 0;
    int            m_bursts = 0;
    logic [DW-1:0] data_q[$];
    int            cmd_len_q[$];
    logic [AW-1:0] cmd_addr_q[$];
    int            acc_total = 0;
    int            out_total = 0;
    int            out_idx = 0;
    int            cyc = 0;
    logic          dl_act = 1'b0;
    int            dl_beat = 0;
    int            dl_cyc = 0;

    // Stimulus-owned request counters read by the checking process.
    int idle_req = 0;
    int idle_seen = 0;
    int budget_hit = 0;

    task automatic check_eq(input string tag, input val_t got, input val_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] next_slot(input logic [AW-1:0] a);
        if (longint'(a) + longint'(STRIDE) >= longint'(m_end)) return m_base;
        return a + AW'(STRIDE);
    endfunction

    task automatic close_burst(input int beats);
        cmd_len_q.push_back(beats - 1);
        cmd_addr_q.push_back(m_addr);
        m_addr = next_slot(m_addr);
        m_bursts++;
        dl_act = 1'b1;
        dl_beat = acc_total;
        dl_cyc = cyc + 1;
    endtask

    task automatic model_clear();
        m_run = 1'b0;
        m_flush = 1'b0;
        m_cnt = 0;
        m_bursts = 0;
        data_q.delete();
        cmd_len_q.delete();
        cmd_addr_q.delete();
        acc_total = 0;
        out_total = 0;
        out_idx = 0;
        dl_act = 1'b0;
    endtask

    task automatic model_step();
        cyc++;
        if (m_flush) begin
            m_flush = 1'b0;
        end else if (m_run) begin
            if (wr_stop) begin
                if (m_cnt > 0) close_burst(m_cnt);
                m_cnt = 0;
                m_run = 1'b0;
                m_flush = 1'b1;
            end else if (user_wr_valid) begin
                data_q.push_back(user_wr_data);
                acc_total++;
                m_cnt++;
                if (m_cnt == BL) begin
                    close_burst(BL);
                    m_cnt = 0;
                end
            end
        end else if (wr_start) begin
            m_run = 1'b1;
            m_base = cfg_base_addr;
            m_end = cfg_end_addr;
            m_addr = cfg_base_addr;
            m_cnt = 0;
            m_bursts = 0;
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ready", val_t'(user_wr_ready), val_t'(0));
        check_eq("rst_req", val_t'(wr_req_en), val_t'(0));
        check_eq("rst_len", val_t'(wr_burst_length), val_t'(0));
        check_eq("rst_addr", val_t'(wr_data_addr), val_t'(0));
        check_eq("rst_din", wr_data_din, val_t'(0));
        check_eq("rst_valid", val_t'(wr_data_valid), val_t'(0));
        check_eq("rst_last", val_t'(wr_data_last), val_t'(0));
        check_eq("rst_busy", val_t'(wr_busy), val_t'(0));
        check_eq("rst_cnt", val_t'(wr_burst_cnt), val_t'(0));
    endtask

    task automatic monitor_step();
        logic exp_last;
        check_eq("ready", val_t'(user_wr_ready), val_t'(m_run && !wr_stop));
        check_eq("busy", val_t'(wr_busy), val_t'(m_run || m_flush));
        if (wr_data_valid) begin
            check_eq("beat_expected", val_t'(data_q.size() != 0), val_t'(1));
            if (data_q.size() != 0) begin
                check_eq("data", wr_data_din, data_q.pop_front());
                out_total++;
                exp_last = (cmd_len_q.size() != 0) && (out_idx == cmd_len_q[0]);
                check_eq("last", val_t'(wr_data_last), val_t'(exp_last));
                check_eq("req", val_t'(wr_req_en), val_t'(exp_last));
                if (exp_last) begin
                    check_eq("len", val_t'(wr_burst_length), val_t'(cmd_len_q.pop_front()));
                    check_eq("addr", val_t'(wr_data_addr), val_t'(cmd_addr_q.pop_front()));
                    out_idx = 0;
                end else begin
                    out_idx++;
                end
            end
        end else begin
            check_eq("req_without_beat", val_t'(wr_req_en), val_t'(0));
            check_eq("last_without_beat", val_t'(wr_data_last), val_t'(0));
        end
        check_eq("outstanding_le1", val_t'((acc_total - out_total) <= 1), val_t'(1));
        if (dl_act && cyc == dl_cyc) begin
            check_eq("close_latency", val_t'(out_total >= dl_beat), val_t'(1));
            dl_act = 1'b0;
        end
        if (idle_req != idle_seen) begin
            idle_seen = idle_req;
            check_eq("idle_beats_left", val_t'(data_q.size()), val_t'(0));
            check_eq("idle_cmds_left", val_t'(cmd_len_q.size()), val_t'(0));
            check_eq("burst_cnt", val_t'(wr_burst_cnt), val_t'(m_bursts));
            check_eq("stim_budget", val_t'(budget_hit), val_t'(0));
        end
    endtask

    // Model advances on rising edges, DUT outputs are checked on falling edges.
    always @(posedge clk or negedge clk) begin
        if (!reset_n) begin
            model_clear();
            if (!clk) check_reset_outputs();
        end else if (clk) begin
            model_step();
        end else begin
            monitor_step();
        end
    end

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [AW-1:0] b, input logic [AW-1:0] e);
        cfg_base_addr = b;
        cfg_end_addr = e;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            user_wr_valid = 1'b1;
            user_wr_data = rand_beat();
            tick();
        end
        user_wr_valid = 1'b0;
    endtask

    task automatic stop_session();
        wr_stop = 1'b1;
        tick();
        wr_stop = 1'b0;
    endtask

    task automatic settle();
        repeat (4) tick();
        idle_req++;
        repeat (2) tick();
    endtask

    initial begin
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Stop while idle must be ignored.
        stop_session();
        settle();

        // Two full bursts back to back.
        start_session(32'h1000, 32'h1200);
        send_beats(32);
        stop_session();
        settle();

        // Third burst wraps to base.
        start_session(32'h1000, 32'h1200);
        send_beats(48);
        stop_session();
        settle();

        // Partial burst closed by flush after an idle gap.
        start_session(32'h1000, 32'h1200);
        send_beats(5);
        repeat (10) tick();
        stop_session();
        settle();

        // Stop together with a valid beat: that beat is refused.
        start_session(32'h1000, 32'h1200);
        send_beats(2);
        user_wr_valid = 1'b1;
        user_wr_data = rand_beat();
        wr_stop = 1'b1;
        tick();
        wr_stop = 1'b0;
        user_wr_valid = 1'b0;
        settle();

        // Reset in the middle of a burst, then a fresh session starting at base.
        start_session(32'h2000, 32'h2400);
        send_beats(7);
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        start_session(32'h2000, 32'h2400);
        send_beats(16);
        stop_session();
        settle();

        // Throttled stream with stray start pulses while running.
        start_session(32'h0, 32'h300);
        begin
            int got = 0;
            int budget = 0;
            while (got < 64 && budget < 2000) begin
                user_wr_valid = 1'($urandom_range(0, 1));
                user_wr_data = rand_beat();
                wr_start = ($urandom_range(0, 15) == 0);
                tick();
                if (user_wr_valid) got++;
                budget++;
            end
            if (got < 64) budget_hit = 1;
        end
        wr_start = 1'b0;
        user_wr_valid = 1'b0;
        repeat (3) tick();
        stop_session();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/wr_burst_gen.md
Name: wr_burst_gen

Overview:
- Upstream write-source stage for wr_buffer, single clock domain.
- Accepts a continuous user beat stream with a valid/ready handshake.
- Slices the stream into AXI-sized bursts on a circular address window. For each burst it emits the beats plus one command: length and address.
- Its outputs drive wr_buffer's wr_req_en/wr_burst_length/wr_data_addr/wr_data_din/wr_data_valid/wr_data_last ports directly.

Parameters:
AXI_DATA_WIDTH, 128, beat width in bits. Legal values: 64, 128, 256.
AXI_ADDR_WIDTH, 32, byte-address width.
BURST_LEN, 16, beats per full burst, 1..256.

Ports:
clk  in  1  single clock for everything.
reset_n  in  1  asynchronous, active-low reset.
cfg_base_addr  in  AXI_ADDR_WIDTH  window start (inclusive). Aligned to BURST_LEN*AXI_DATA_WIDTH/8.
cfg_end_addr  in  AXI_ADDR_WIDTH  window end (exclusive). Same alignment.
wr_start  in  1  pulse: latch cfg_*, begin a session.
wr_stop  in  1  pulse: close the open burst, end the session.
user_wr_data  in  AXI_DATA_WIDTH  user beat.
user_wr_valid  in  1  user beat valid.
user_wr_ready  out  1  beat accepted when valid&&ready.
wr_req_en  out  1  one-cycle command strobe.
wr_burst_length  out  8  AXI len encoding (beats-1).
wr_data_addr  out  AXI_ADDR_WIDTH  burst start byte address.
wr_data_din  out  AXI_DATA_WIDTH  beat data.
wr_data_valid  out  1  beat strobe.
wr_data_last  out  1  final beat of burst.
wr_busy  out  1  high while not IDLE.
wr_burst_cnt  out  32  bursts issued since wr_start.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, hold register empty, counters 0.
- Reset mid-burst: the open partial burst is discarded; no wr_req_en is issued for it.
- All outputs except user_wr_ready are registered.
- user_wr_ready = (state==RUN) && !wr_stop, combinational.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE --wr_start--> RUN. On this transition: latch base/end, set addr_ptr=base, beat_cnt=0, wr_burst_cnt=0.
  - RUN --wr_stop--> FLUSH.
  - FLUSH --> IDLE after one cycle.
  - wr_start in RUN or FLUSH: ignored.
  - wr_stop in IDLE: ignored.
- Hold register: one beat deep. Every accepted beat enters the hold register, and beat_cnt increments. This ensures wr_data_last can always be placed on a real beat.
- Output stage: on a clock edge the held beat moves to the outputs (wr_data_valid=1) when any of these holds:
  - a new beat is accepted this cycle, or
  - the held beat is burst-final (its index == BURST_LEN-1), or
  - state==FLUSH with the hold register occupied.
  At most one beat is output per cycle. A newly accepted beat refills the hold register on the same edge.
- Burst close: when the output beat is burst-final, or the FLUSH drain beat:
  - same cycle: wr_data_last=1, wr_req_en=1.
  - wr_burst_length = beats in burst - 1: BURST_LEN-1 for a full burst, beat_cnt-1 for a flush.
  - wr_data_addr = addr_ptr of this burst.
- Command and last beat are coincident, so the command never precedes its data into wr_buffer.
- After a close:
  - addr_ptr += BURST_LEN*AXI_DATA_WIDTH/8; if the result >= cfg_end_addr, addr_ptr = cfg_base_addr (wrap).
  - beat_cnt = 0 (or 1 if a beat was accepted on the same edge).
  - wr_burst_cnt++ (wraps at 2^32).
- A partial (flushed) burst still advances addr_ptr by a full burst stride, so burst slots stay aligned.
- FLUSH with the hold register empty (no open burst): no output, return to IDLE.
- Simultaneous wr_stop and user_wr_valid: the beat is not accepted.
- Latency:
  - non-final beat: output on the edge after the next accepted beat, or on flush.
  - final beat: output 2 edges after acceptance, then visible.
- wr_data_valid, wr_data_last and wr_req_en are each high for exactly one cycle per event.
- wr_busy = (state!=IDLE).

Test Plan:
- DW=128, BURST_LEN=16, base=0x1000, end=0x1200, 32 back-to-back beats → two bursts at 0x1000 and 0x1100, wr_burst_length=15, each last beat with wr_req_en, wr_burst_cnt=2.
- Same configuration, 48 beats → the third burst wraps to 0x1000 (addr 0x1200 >= end).
- 5 beats, idle 10 cycles, wr_stop → beats 1-4 output as accepted, beat 5 output in FLUSH with last=1, wr_req_en, wr_burst_length=4, addr=0x1000. Next session burst lands at 0x1100 if not restarted.
- wr_stop asserted together with user_wr_valid on beat 3 → that beat is refused, burst closes with length 1 (2 beats).
- Assert reset_n=0 after 7 beats of a burst → all outputs 0 immediately, no wr_req_en. After release and wr_start, the first burst is at base.
- Throttled user_wr_valid (random 50%) for 64 beats → output data sequence identical to input, 4 commands, no cycle with two beats output.
